// File: rtl/res_collector_pkg.sv
// -----------------------------------------------------------------------------
// res_collector_pkg
//
// Shared definitions for the fsm_design result collector:
//   - coll_state_e : collector FSM states (IDLE, COLLECT, HOLD, DROP)
//   - S0..S7, IDLE_C, INPUT_C, OUTPUT_C : state codes reported by fsm_design
//     on its state_res output
//   - nib_count()  : number of nibbles that make up one result word
//   - is_op_code() : true for the operation states S0..S7
// -----------------------------------------------------------------------------
package res_collector_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      HOLD    = 2'd2,
      DROP    = 2'd3
   } coll_state_e;

   // fsm_design state_res encoding
   localparam logic [3:0] S0       = 4'd0;
   localparam logic [3:0] S1       = 4'd1;
   localparam logic [3:0] S2       = 4'd2;
   localparam logic [3:0] S3       = 4'd3;
   localparam logic [3:0] S4       = 4'd4;
   localparam logic [3:0] S5       = 4'd5;
   localparam logic [3:0] S6       = 4'd6;
   localparam logic [3:0] S7       = 4'd7;
   localparam logic [3:0] IDLE_C   = 4'd8;
   localparam logic [3:0] INPUT_C  = 4'd9;
   localparam logic [3:0] OUTPUT_C = 4'd10;

   // Nibbles per result word.
   function automatic int nib_count(input int n, input int n_width);
      return n / n_width;
   endfunction

   // Operation states are the only codes that update the remembered opcode.
   function automatic logic is_op_code(input logic [3:0] code);
      return code inside {S0, S1, S2, S3, S4, S5, S6, S7};
   endfunction

endpackage

// File: rtl/res_collector_nibble_assembler.sv
// -----------------------------------------------------------------------------
// res_collector_nibble_assembler
//
// Index counter plus assembly register. Each write strobe stores i_nibble at
// bit slice [idx*N_width +: N_width] and advances the index; the write that
// lands on the last slot wraps the index back to zero.
//
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   i_wr       : store i_nibble at the current index, then advance
//   i_clr      : abandon the partial frame (index back to 0)
//   i_nibble   : incoming nibble
//   o_last     : current index is the final nibble slot
//   o_word     : assembly register with i_nibble merged in at the current
//                index, i.e. the completed word when i_wr & o_last
// -----------------------------------------------------------------------------
module res_collector_nibble_assembler
   import res_collector_pkg::*;
#(
   parameter int N       = 64,
   parameter int N_width = 4
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_wr,
   input  logic               i_clr,
   input  logic [N_width-1:0] i_nibble,
   output logic               o_last,
   output logic [N-1:0]       o_word
);

   localparam int               NIB      = nib_count(N, N_width);
   localparam int               IDX_W    = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

   logic [IDX_W-1:0] r_idx;
   logic [N-1:0]     r_asm;
   logic [N-1:0]     w_word;

   // NOTE: every signal driven in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_word = r_asm;
      w_word[int'(r_idx) * N_width +: N_width] = i_nibble;
   end

   assign o_word = w_word;
   assign o_last = (r_idx == LAST_IDX);

   // NOTE: the assembly register is a plain data register, but it is still
   // brought to a known value on reset so out_data never shows X-derived bits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_idx <= '0;
         r_asm <= '0;
      end else begin
         if (i_wr) begin
            r_asm <= w_word;
            r_idx <= o_last ? '0 : r_idx + 1'b1;
         end else if (i_clr) begin
            r_idx <= '0;
         end
      end
   end

endmodule

// File: rtl/res_collector.sv
// -----------------------------------------------------------------------------
// res_collector
//
// Downstream stage of fsm_design. Reassembles the nibble-serial result stream
// (LSB nibble first) into N-bit words, tags each word with the last operation
// state S0..S7 seen before the frame, and offers it on a valid/ready port.
//
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   in_valid     : fsm_design output_valid
//   in_nibble    : fsm_design out
//   in_state     : fsm_design state_res
//   out_valid    : assembled word available
//   out_ready    : consumer accepts word (transfer = out_valid & out_ready)
//   out_data     : assembled result, stable while out_valid
//   out_op       : last S-state code before the frame
//   frame_count  : words accepted by the consumer, wraps
//   frame_err    : sticky, a frame ended before NIB nibbles
//   overflow     : sticky, a frame arrived while a word was still held
//   clr_flags    : synchronous clear of frame_err/overflow (set wins)
//
// FSM:
//   IDLE    -> waiting for the first nibble of a frame
//   COLLECT -> frame in progress
//   HOLD    -> completed word waiting for the consumer
//   DROP    -> frame arrived during HOLD; its nibbles are discarded until
//              in_valid falls, while consumer transfers are still honoured
// -----------------------------------------------------------------------------
module res_collector
   import res_collector_pkg::*;
#(
   parameter int N       = 64,
   parameter int N_width = 4,
   parameter int CNT_W   = 8
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [N_width-1:0] in_nibble,
   input  logic [3:0]         in_state,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [N-1:0]       out_data,
   output logic [2:0]         out_op,
   output logic [CNT_W-1:0]   frame_count,
   output logic               frame_err,
   output logic               overflow,
   input  logic               clr_flags
);

   coll_state_e      r_state;
   coll_state_e      w_next_state;

   logic             r_out_valid;
   logic [N-1:0]     r_out_data;
   logic [2:0]       r_out_op;
   logic [2:0]       r_last_op;
   logic [CNT_W-1:0] r_frame_count;
   logic             r_frame_err;
   logic             r_overflow;

   logic             w_xfer;
   logic             w_wr;
   logic             w_clr;
   logic             w_complete;
   logic             w_set_ferr;
   logic             w_set_ovf;
   logic             w_last;
   logic [N-1:0]     w_word;

   assign w_xfer = r_out_valid & out_ready;

   res_collector_nibble_assembler #(
      .N       (N),
      .N_width (N_width)
   ) u_nibble_assembler (
      .clk      (clk),
      .rst      (rst),
      .i_wr     (w_wr),
      .i_clr    (w_clr),
      .i_nibble (in_nibble),
      .o_last   (w_last),
      .o_word   (w_word)
   );

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and control strobes
   // ---------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      w_wr         = 1'b0;
      w_clr        = 1'b0;
      w_complete   = 1'b0;
      w_set_ferr   = 1'b0;
      w_set_ovf    = 1'b0;

      unique case (r_state)
         IDLE: begin
            if (in_valid) begin
               w_wr = 1'b1;
               if (w_last) begin
                  w_complete   = 1'b1;
                  w_next_state = HOLD;
               end else begin
                  w_next_state = COLLECT;
               end
            end
         end

         COLLECT: begin
            if (in_valid) begin
               w_wr = 1'b1;
               if (w_last) begin
                  w_complete   = 1'b1;
                  w_next_state = HOLD;
               end
            end else begin
               // Short frame: throw the partial word away.
               w_set_ferr   = 1'b1;
               w_clr        = 1'b1;
               w_next_state = IDLE;
            end
         end

         HOLD: begin
            if (in_valid) begin
               if (w_xfer) begin
                  // Held word leaves this cycle, so the new frame's first
                  // nibble can be taken without loss.
                  w_wr = 1'b1;
                  if (w_last) begin
                     w_complete   = 1'b1;
                     w_next_state = HOLD;
                  end else begin
                     w_next_state = COLLECT;
                  end
               end else begin
                  w_set_ovf    = 1'b1;
                  w_next_state = DROP;
               end
            end else if (w_xfer) begin
               w_next_state = IDLE;
            end
         end

         DROP: begin
            if (!in_valid) begin
               w_next_state = (r_out_valid && !w_xfer) ? HOLD : IDLE;
            end
         end

         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output word, handshake, counter, opcode tracking
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out_valid   <= 1'b0;
         r_out_data    <= '0;
         r_out_op      <= '0;
         r_last_op     <= '0;
         r_frame_count <= '0;
      end else begin
         // A completion in the same cycle as a transfer means a new word
         // replaces the one just accepted, so completion takes priority.
         if (w_complete) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_word;
            r_out_op    <= r_last_op;
         end else if (w_xfer) begin
            r_out_valid <= 1'b0;
         end

         if (w_xfer) begin
            r_frame_count <= r_frame_count + 1'b1;
         end

         if (is_op_code(in_state)) begin
            r_last_op <= in_state[2:0];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Sticky flags: a set event in the clearing cycle still leaves the flag set
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_frame_err <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_frame_err <= w_set_ferr | (r_frame_err & ~clr_flags);
         r_overflow  <= w_set_ovf  | (r_overflow  & ~clr_flags);
      end
   end

   assign out_valid   = r_out_valid;
   assign out_data    = r_out_data;
   assign out_op      = r_out_op;
   assign frame_count = r_frame_count;
   assign frame_err   = r_frame_err;
   assign overflow    = r_overflow;

endmodule

// File: doc/res_collector.md
Name: res_collector

Overview:
- Downstream stage of fsm_design. Consumes the nibble-serial result stream (out, output_valid) and the state code (state_res).
- Reassembles each N-bit result, tags it with the last operation state (S0..S7) the FSM visited before OUTPUT, and presents it on a valid/ready word interface.
- Flags malformed frames and results dropped while the output is still held.

Parameters:
- N, 64, result word width; must equal fsm_design N.
- N_width, 4, nibble width; must equal fsm_design N_width.
- CNT_W, 8, width of completed-frame counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  from fsm_design output_valid.
- in_nibble  in  N_width  from fsm_design out.
- in_state  in  4  from fsm_design state_res.
- out_valid  out  1  assembled word available.
- out_ready  in  1  consumer accepts word.
- out_data  out  N  assembled result.
- out_op  out  3  last S-state code (0..7) before the frame.
- frame_count  out  CNT_W  number of words accepted by consumer; wraps.
- frame_err  out  1  sticky: frame ended early.
- overflow  out  1  sticky: frame arrived while word held.
- clr_flags  in  1  synchronous clear of frame_err and overflow.

Behaviour:
- Constants: NIB = N/N_width (16 by default). Nibble k is stored at bits [k*N_width +: N_width]. The first nibble received is k=0 (LSB).
- Reset (rst low, async): FSM=IDLE, nibble index=0, assembly reg=0, out_data=0, out_valid=0, out_op=0, last_op=0, frame_count=0, frame_err=0, overflow=0.
- last_op tracking: every cycle, when in_state < 8, last_op <= in_state[2:0]. Codes 8/9/10 (IDLE/INPUT/OUTPUT) leave it unchanged.
- States: IDLE, COLLECT, HOLD, DROP.
- IDLE:
  - in_valid=1: write nibble 0, idx<=1, go COLLECT.
- COLLECT:
  - in_valid=1: write nibble idx.
  - If idx==NIB-1: copy the completed word to out_data, out_op<=last_op, out_valid<=1 next cycle, go HOLD.
  - Otherwise idx<=idx+1.
  - in_valid=0 before completion: frame_err<=1, discard, idx<=0, go IDLE.
- Latency: out_valid rises on the clock edge after the clock that captures nibble NIB-1. From the first nibble, that is NIB cycles.
- HOLD:
  - out_data and out_op stay stable while out_valid=1.
  - Transfer occurs when out_valid & out_ready. On transfer: out_valid<=0 and frame_count<=frame_count+1 (wraps).
  - Transfer and in_valid in the same cycle: capture nibble 0, idx<=1, go COLLECT. No data loss.
  - in_valid without transfer: overflow<=1, go DROP.
  - Transfer without in_valid: go IDLE.
- DROP:
  - Ignores in_nibble until in_valid=0.
  - out_ready transfers are still honoured.
  - On in_valid=0: go HOLD if the word is still unaccepted, else IDLE.
- Upstream guarantee: in_valid is high for exactly NIB contiguous cycles per frame. Any shortfall is a frame_err.
- Flags:
  - clr_flags clears frame_err and overflow synchronously.
  - A set event in the same cycle as clr_flags wins (flag=1).
- Assembly register: holds partial data between frames and is not cleared. Only out_data is architecturally visible.
- Reset mid-frame or mid-HOLD: immediate return to reset values. The held word is lost.

Decomposition:
- Package res_collector_pkg:
  - collector state enum (IDLE, COLLECT, HOLD, DROP).
  - localparam codes for fsm_design states: S0..S7 = 0..7, IDLE_C = 8, INPUT_C = 9, OUTPUT_C = 10.
  - helper function nib_count(N, N_width).
- One sub-module is natural: nibble_assembler (index counter plus indexed part-select write, done/clear strobes). The FSM, flags and handshake live in res_collector.

Test Plan:
- Reset, then 16 cycles in_valid=1 with in_nibble=k at cycle k, in_state=10, last in_state<8 was 5, out_ready=0 → out_valid=1 one cycle after the last nibble; out_data=64'hFEDCBA9876543210; out_op=5; frame_count=0.
- From case 1, raise out_ready for 1 cycle → out_valid=0 next cycle; frame_count=1. Then 3 more full frames accepted → frame_count=4.
- Frame with in_valid dropping after 7 nibbles → frame_err=1, out_valid stays 0. Next full frame of all 4'hA → out_data=64'hAAAA_AAAA_AAAA_AAAA. clr_flags pulse → frame_err=0.
- Hold word W1 (out_ready=0), send frame W2 → overflow=1, out_data stays W1 throughout. Accept W1 → frame_count+1, out_valid=0, W2 never appears.
- Back-to-back: out_ready=1 in the exact cycle the W2 first nibble arrives → W1 accepted, W2=64'h0123456789ABCDEF assembled correctly, overflow=0.
- Assert rst low mid-COLLECT (nibble 9) → all outputs zero immediately. A fresh full frame afterwards assembles correctly.
